// File: rtl/cam_if_pkg.sv
// cam_if_pkg: output-mode constants, output width rule and
// pixel formatting shared by the DVP capture path.
package cam_if_pkg;
  localparam int MODE_RGB565 = 0;
  localparam int MODE_RGB444 = 1;

  function automatic int out_w(input int mode);
    return (mode == MODE_RGB444) ? 12 : 16;
  endfunction

  // Pixel is {R5,G6,B5}; RGB444 keeps the top bits of each field.
  function automatic logic [15:0] rgb565_fmt(
    input logic [15:0] pix,
    input int          mode,
    input logic        rb_swap
  );
    logic [15:0] p;
    p = rb_swap ? {pix[4:0], pix[10:5], pix[15:11]} : pix;
    if (mode == MODE_RGB444)
      return {4'h0, p[15:12], p[10:7], p[4:1]};
    return p;
  endfunction

  function automatic logic in_win(
    input int unsigned v,
    input int unsigned lo,
    input int unsigned hi
  );
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/cam_byte_assembler.sv
// cam_byte_assembler: pairs registered camera bytes into pixels and
// flags lines that end on an unpaired byte.
module cam_byte_assembler
  import cam_if_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BYTE_SWAP = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clr,
  input  logic                i_hs,
  input  logic [DATA_W-1:0]   i_data,
  output logic                o_done,
  output logic [2*DATA_W-1:0] o_pix,
  output logic                o_err_odd
);
  logic              r_phase;
  logic [DATA_W-1:0] r_hi;
  logic [2*DATA_W-1:0] w_pix;
  logic              w_done;

  assign w_pix  = (BYTE_SWAP != 0) ? {i_data, r_hi} : {r_hi, i_data};
  assign w_done = i_hs & r_phase & ~i_clr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phase   <= 1'b0;
      r_hi      <= '0;
      o_done    <= 1'b0;
      o_pix     <= '0;
      o_err_odd <= 1'b0;
    end else begin
      o_done    <= w_done;
      o_err_odd <= ~i_hs & r_phase & ~i_clr;
      if (w_done)
        o_pix <= w_pix;
      if (i_clr || !i_hs)
        r_phase <= 1'b0;
      else
        r_phase <= ~r_phase;
      if (i_hs && !r_phase)
        r_hi <= i_data;
    end
  end
endmodule

// File: rtl/camera_dvp_capture.sv
// camera_dvp_capture: DVP pixel-clock front-end with frame sync, crop,
// frame decimation and RGB565/RGB444 output formatting.
module camera_dvp_capture
  import cam_if_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OUT_MODE   = 1,
  parameter int BYTE_SWAP  = 0,
  parameter int RB_SWAP    = 1,
  parameter int VSYNC_POL  = 1,
  parameter int CNT_W      = 12,
  parameter int CROP_X0    = 0,
  parameter int CROP_X1    = 4095,
  parameter int CROP_Y0    = 0,
  parameter int CROP_Y1    = 4095,
  parameter int FRAME_SKIP = 0,
  localparam int OUT_W     = out_w(OUT_MODE)
) (
  input  logic              i_clk_pixel,
  input  logic              i_rst,
  input  logic              i_camera_hsync,
  input  logic              i_camera_vsync,
  input  logic [DATA_W-1:0] i_camera_data,
  output logic              o_vde,
  output logic              o_vsync,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_sof,
  output logic              o_eol,
  output logic [CNT_W-1:0]  o_x,
  output logic [CNT_W-1:0]  o_y,
  output logic              o_err_odd
);
  logic                r_hs, r_hs_d, r_vs1, r_vs2;
  logic [DATA_W-1:0]   r_data;
  logic [CNT_W-1:0]    r_x, r_y;
  logic                r_xwrap, r_armed, r_emit, r_drop, r_sof_pend;
  logic [15:0]         r_skip;
  logic                w_fs, w_fall, w_done, w_vde, w_lend;
  logic [2*DATA_W-1:0] w_pix;
  logic [OUT_W-1:0]    w_fmt;

  assign w_fs    = r_vs1 & ~r_vs2;
  assign w_fall  = r_hs_d & ~r_hs;
  assign o_vsync = r_vs2;
  // Line ends right after this pixel: hsync already low, or one odd byte left.
  assign w_lend  = ~r_hs | ~i_camera_hsync;
  assign w_fmt   = OUT_W'(rgb565_fmt(16'(w_pix), OUT_MODE, RB_SWAP != 0));
  assign w_vde   = w_done & r_armed & r_emit & ~r_drop & ~r_xwrap
                 & in_win(32'(r_x), CROP_X0, CROP_X1)
                 & in_win(32'(r_y), CROP_Y0, CROP_Y1);

  cam_byte_assembler #(
    .DATA_W    (DATA_W),
    .BYTE_SWAP (BYTE_SWAP)
  ) u_asm (
    .i_clk     (i_clk_pixel),
    .i_rst     (i_rst),
    .i_clr     (w_fs),
    .i_hs      (r_hs),
    .i_data    (r_data),
    .o_done    (w_done),
    .o_pix     (w_pix),
    .o_err_odd (o_err_odd)
  );

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      r_hs   <= 1'b0;
      r_hs_d <= 1'b0;
      r_data <= '0;
      r_vs1  <= 1'b0;
      r_vs2  <= 1'b0;
    end else begin
      r_hs   <= i_camera_hsync;
      r_hs_d <= r_hs;
      r_data <= i_camera_data;
      r_vs1  <= (i_camera_vsync == 1'(VSYNC_POL));
      r_vs2  <= r_vs1;
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xwrap <= 1'b0;
    end else if (w_fs) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xwrap <= 1'b0;
    end else if (w_fall) begin
      r_x     <= '0;
      r_xwrap <= 1'b0;
      if (r_y != '1)
        r_y <= r_y + 1'b1;
    end else if (w_done) begin
      r_x <= r_x + 1'b1;
      if (r_x == '1)
        r_xwrap <= 1'b1;
    end
  end

  // Frame start owns the frame: arm, pick emit/skip, drop a live line.
  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      r_armed    <= 1'b0;
      r_emit     <= 1'b0;
      r_skip     <= '0;
      r_drop     <= 1'b0;
      r_sof_pend <= 1'b0;
    end else if (w_fs) begin
      r_armed    <= 1'b1;
      r_emit     <= (r_skip == '0);
      r_skip     <= (r_skip == 16'(FRAME_SKIP)) ? '0 : r_skip + 1'b1;
      r_drop     <= r_hs;
      r_sof_pend <= 1'b1;
    end else begin
      if (!r_hs)
        r_drop <= 1'b0;
      if (w_vde)
        r_sof_pend <= 1'b0;
    end
  end

  always_ff @(posedge i_clk_pixel or posedge i_rst) begin
    if (i_rst) begin
      o_vde  <= 1'b0;
      o_data <= '0;
      o_sof  <= 1'b0;
      o_eol  <= 1'b0;
      o_x    <= '0;
      o_y    <= '0;
    end else begin
      o_vde  <= w_vde;
      o_data <= w_vde ? w_fmt : '0;
      o_sof  <= w_vde & r_sof_pend;
      o_eol  <= w_vde & ((32'(r_x) == CROP_X1) | w_lend);
      o_x    <= w_vde ? r_x : '0;
      o_y    <= w_vde ? r_y : '0;
    end
  end
endmodule
